// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STALL
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } rf_wr_t;

  localparam rf_wr_t RF_WR_NONE = '0;

endpackage

// File: rtl/rf_skid1.sv
// One-entry capture/drain buffer for a pipeline write that collides with a forced debug slot.
module rf_skid1
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [REG_AW-1:0] in_addr,
  input  logic [REG_DW-1:0] in_data,
  output logic              full,
  output logic [REG_AW-1:0] addr,
  output logic [REG_DW-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload has no reset; it is only ever read while full is set.
  always_ff @(posedge clk) begin
    if (push) begin
      addr <= in_addr;
      data <= in_data;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between the WB stage and a debug channel,
// with a starvation counter that forces a one-cycle debug slot.
module regfile_wr_arbiter
  import rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [REG_DW-1:0] wb_data,
  input  logic              dbg_valid,
  input  logic [REG_AW-1:0] dbg_addr,
  input  logic [REG_DW-1:0] dbg_data,
  output logic              dbg_ready,
  output logic              stall_req,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_addr,
  output logic [REG_DW-1:0] rf_data
);

  localparam logic [7:0] WCNT_LAST = 8'(STARVE_LIMIT - 1);

  arb_state_t        state, state_nxt;
  logic [7:0]        wcnt, wcnt_nxt;
  logic              stall_nxt;
  rf_wr_t            issue, rf_q;
  logic              wb_live;
  logic              skid_push, skid_pop, skid_full;
  logic [REG_AW-1:0] skid_addr;
  logic [REG_DW-1:0] skid_data;

  // Writes to x0 never reach the register file.
  assign wb_live = wb_we && (wb_addr != '0);

  rf_skid1 u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (skid_push),
    .pop     (skid_pop),
    .in_addr (wb_addr),
    .in_data (wb_data),
    .full    (skid_full),
    .addr    (skid_addr),
    .data    (skid_data)
  );

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    stall_nxt = stall_req;
    issue     = RF_WR_NONE;
    dbg_ready = 1'b0;
    skid_push = 1'b0;
    skid_pop  = 1'b0;

    case (state)
      STALL: begin
        // Forced slot: the pipeline only sees stall_req next cycle, so a
        // WB write arriving now is parked in the skid buffer.
        dbg_ready = dbg_valid;
        skid_push = wb_live;
        state_nxt = IDLE;
        wcnt_nxt  = '0;
        stall_nxt = 1'b0;
      end
      default: begin
        if (skid_full) begin
          skid_pop = 1'b1;
          issue    = '{1'b1, skid_addr, skid_data};
        end else if (wb_live) begin
          issue = '{1'b1, wb_addr, wb_data};
        end else begin
          dbg_ready = 1'b1;
        end

        if (!dbg_valid || dbg_ready) begin
          state_nxt = IDLE;
          wcnt_nxt  = '0;
        end else if (state == IDLE) begin
          state_nxt = WAIT;
        end else if (wcnt == WCNT_LAST) begin
          state_nxt = STALL;
          stall_nxt = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
    endcase

    if (dbg_valid && dbg_ready && (dbg_addr != '0)) begin
      issue = '{1'b1, dbg_addr, dbg_data};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      stall_req <= 1'b0;
      rf_q      <= RF_WR_NONE;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      stall_req <= stall_nxt;
      rf_q      <= issue;
    end
  end

  assign rf_we   = rf_q.we;
  assign rf_addr = rf_q.addr;
  assign rf_data = rf_q.data;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, and
// random traffic against a priority/age reference model.
module tb_regfile_wr_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we, dbg_valid;
  logic [4:0]  wb_addr, dbg_addr;
  logic [31:0] wb_data, dbg_data;
  logic        dbg_ready, stall_req, rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .dbg_valid (dbg_valid),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_ready (dbg_ready),
    .stall_req (stall_req),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                       input logic dv, input logic [4:0] da, input logic [31:0] dd);
    wb_we = wwe; wb_addr = wa; wb_data = wd;
    dbg_valid = dv; dbg_addr = da; dbg_data = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf(input string name, input logic we, input logic [4:0] a,
                          input logic [31:0] d, input logic st);
    check({name, "_rf_we"}, rf_we, we);
    if (we) begin
      check({name, "_rf_addr"}, rf_addr, a);
      check({name, "_rf_data"}, rf_data, d);
    end
    check({name, "_stall"}, stall_req, st);
  endtask

  // Debug to x9 blocked by a continuous WB stream to x3 until the forced slot.
  task automatic starve(input string name);
    for (int c = 0; c < LIMIT + 1; c++) begin
      drive(1'b1, 5'd3, 32'h30 + c, 1'b1, 5'd9, 32'h9999_0009);
      #3;
      check($sformatf("%s_blk%0d_ready", name, c), dbg_ready, 1'b0);
      tick();
      check_rf($sformatf("%s_blk%0d", name, c), 1'b1, 5'd3, 32'h30 + c, c == LIMIT);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        dbg_valid;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        exp_ready;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[7];

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t held[$];
  bit  forced;
  int  blocked;

  task automatic model_step(input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                            input logic dv, input logic [4:0] da, input logic [31:0] dd,
                            output logic exp_ready, output wr_t iss);
    bit wb_live, accept;
    wb_live   = wwe && (wa != 0);
    iss       = '0;
    exp_ready = 1'b0;
    if (held.size() > 0) begin
      check("no_wb_in_drain", wb_live, 1'b0);
      iss = held.pop_front();
    end else if (forced) begin
      exp_ready = dv;
      if (wb_live) held.push_back('{1'b1, wa, wd});
    end else if (wb_live) begin
      iss = '{1'b1, wa, wd};
    end else begin
      exp_ready = 1'b1;
    end
    accept = dv && exp_ready;
    if (accept && da != 0) iss = '{1'b1, da, dd};
    // A request blocked for more than LIMIT consecutive cycles earns a slot.
    if (forced) begin
      forced  = 1'b0;
      blocked = 0;
    end else if (dv && !accept) begin
      blocked++;
      if (blocked > LIMIT) forced = 1'b1;
    end else begin
      blocked = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_ready, pend, wwe, prev_stall;
    logic [4:0]  pa, wa;
    logic [31:0] pd, wd;
    wr_t         iss;
    int          age, n_model_wr, n_dut_wr;

    vecs[0] = '{1'b1, 5'd5,  32'hA5A5_0001, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 5'd5,  32'hA5A5_0001, 1'b0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd17, 32'h1234_5678, 1'b1, 1'b1, 5'd17, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd2,  32'h2222_2222, 1'b1, 1'b1, 5'd2,  32'h2222_2222, 1'b0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 5'd0,  32'h0,         1'b0};
    vecs[5] = '{1'b1, 5'd7,  32'h0000_0707, 1'b1, 5'd9,  32'h0000_0909, 1'b0, 1'b1, 5'd7,  32'h0000_0707, 1'b0};
    vecs[6] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  32'h0000_0909, 1'b1, 1'b1, 5'd9,  32'h0000_0909, 1'b0};

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #12;
    check("reset_stall", stall_req, 1'b0);
    check("reset_rf_we", rf_we, 1'b0);
    check("reset_rf_addr", rf_addr, 5'd0);
    check("reset_rf_data", rf_data, 32'h0);
    rst_n = 1'b1;
    tick();

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      drive(vecs[i].wb_we, vecs[i].wb_addr, vecs[i].wb_data,
            vecs[i].dbg_valid, vecs[i].dbg_addr, vecs[i].dbg_data);
      #3;
      check($sformatf("vec%0d_ready", i), dbg_ready, vecs[i].exp_ready);
      tick();
      check_rf($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_addr,
               vecs[i].exp_data, vecs[i].exp_stall);
    end

    // ---------------- starvation and skid ----------------
    starve("starve");
    drive(1'b1, 5'd3, 32'h35, 1'b1, 5'd9, 32'h9999_0009);
    #3;
    check("stall_slot_ready", dbg_ready, 1'b1);
    tick();
    check_rf("stall_slot", 1'b1, 5'd9, 32'h9999_0009, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #3;
    check("drain_ready", dbg_ready, 1'b0);
    tick();
    check_rf("drain", 1'b1, 5'd3, 32'h35, 1'b0);
    #3;
    check("after_drain_ready", dbg_ready, 1'b1);
    tick();
    check_rf("after_drain", 1'b0, 5'd0, 32'h0, 1'b0);

    // ---------------- reset mid-STALL ----------------
    starve("rst");
    drive(1'b1, 5'd3, 32'h77, 1'b1, 5'd9, 32'h9999_0009);
    #2;
    check("pre_rst_stall", stall_req, 1'b1);
    check("pre_rst_rf_we", rf_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_stall", stall_req, 1'b0);
    check("async_rst_rf_we", rf_we, 1'b0);
    check("async_rst_rf_addr", rf_addr, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_rf($sformatf("post_rst%0d", c), 1'b0, 5'd0, 32'h0, 1'b0);
    end

    // ---------------- random traffic vs model ----------------
    held.delete();
    forced = 1'b0;
    blocked = 0;
    pend = 1'b0;
    pa = '0;
    pd = '0;
    age = 0;
    prev_stall = 1'b0;
    n_model_wr = 0;
    n_dut_wr = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pend && $urandom_range(0, 9) < 4) begin
        pend = 1'b1;
        pa   = 5'($urandom_range(0, 31));
        pd   = $urandom;
        age  = 0;
      end
      // The pipeline reacts to stall_req one cycle late.
      wwe = !prev_stall && ($urandom_range(0, 9) < 6);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      drive(wwe, wa, wd, pend, pa, pd);
      #3;
      model_step(wwe, wa, wd, pend, pa, pd, exp_ready, iss);
      check($sformatf("rnd%0d_ready", c), dbg_ready, exp_ready);
      if (pend && dbg_ready) begin
        check($sformatf("rnd%0d_dbg_latency_ok", c), age <= LIMIT + 1, 1'b1);
        pend = 1'b0;
      end else if (pend) begin
        age++;
      end
      prev_stall = stall_req;
      tick();
      check_rf($sformatf("rnd%0d", c), iss.we, iss.addr, iss.data, forced);
      if (iss.we) n_model_wr++;
      if (rf_we) n_dut_wr++;
    end
    check("rnd_write_count", n_dut_wr, n_model_wr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
